vga_timing_gen: RTL and testbench

Display timing generator for the VGA path. Produces horizontal and vertical sync, the `video_on` blanking qualifier, and the current pixel column and row. Feeds the map/icon lookup logic and the colorizer stage, which gates RGB to black whenever `video_on` is low. Default parameters give 640x480 @ 60 Hz from a 100 MHz system clock through an internal divide-by-4 pixel enable.

---
 rtl/vga_timing_gen.sv | 123 ++++++++++++
 tb/tb_vga_timing_gen.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA horizontal/vertical timing generator with pixel enable
//
// Purpose: divides clk down to a pixel rate, runs the column/row counters and
// produces registered sync, blanking and position outputs for the VGA path.
//
// Ports:
//   clk           system clock, rising-edge active
//   reset         asynchronous, active-high
//   pix_tick      high for the first clk cycle of every pixel period
//   horiz_sync    horizontal sync, at SYNC_POL while asserted
//   vert_sync     vertical sync, at SYNC_POL while asserted
//   video_on      high while the current pixel is in the visible region
//   pixel_column  horizontal counter, 0..H_TOTAL-1
//   pixel_row     vertical counter, 0..V_TOTAL-1
//   frame_start   one-clk pulse as the counters enter (0,0)

module vga_timing_gen #(
    parameter int   CLK_DIV  = 4,
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    output logic       pix_tick,
    output logic       horiz_sync,
    output logic       vert_sync,
    output logic       video_on,
    output logic [9:0] pixel_column,
    output logic [9:0] pixel_row,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [3:0] DIV_MAX = 4'(CLK_DIV - 1);
    localparam logic [9:0] HC_MAX  = 10'(H_TOTAL - 1);
    localparam logic [9:0] VC_MAX  = 10'(V_TOTAL - 1);

    // Decode bounds are 11 bits wide so an end bound of exactly 1024 still compares correctly.
    localparam logic [10:0] H_VIS_END  = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_VIS_END  = 11'(V_ACTIVE);
    localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [3:0] div_q, div_d;
    logic [9:0] hc_q, hc_d;
    logic [9:0] vc_q, vc_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       vo_q, vo_d;
    logic       tick_q, tick_d;
    logic       fs_q, fs_d;
    logic       advance;
    logic [10:0] hc_w, vc_w;

    always_comb begin
        advance = (div_q == DIV_MAX);
        div_d   = advance ? 4'd0 : div_q + 4'd1;
        hc_d    = hc_q;
        vc_d    = vc_q;
        if (advance) begin
            if (hc_q == HC_MAX) begin
                hc_d = 10'd0;
                vc_d = (vc_q == VC_MAX) ? 10'd0 : vc_q + 10'd1;
            end else begin
                hc_d = hc_q + 10'd1;
            end
        end

        // Outputs are decoded from the next-state counters so they move on the
        // same edge as the counters themselves.
        hc_w   = {1'b0, hc_d};
        vc_w   = {1'b0, vc_d};
        hs_d   = ((hc_w >= H_SYNC_BEG) && (hc_w < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
        vs_d   = ((vc_w >= V_SYNC_BEG) && (vc_w < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
        vo_d   = (hc_w < H_VIS_END) && (vc_w < V_VIS_END);
        tick_d = (div_d == 4'd0);
        fs_d   = tick_d && (hc_d == 10'd0) && (vc_d == 10'd0);
    end

    // Counters reset to their final values so the first edge after release
    // is an advance into (0,0) and the first frame is complete.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q  <= DIV_MAX;
            hc_q   <= HC_MAX;
            vc_q   <= VC_MAX;
            hs_q   <= ~SYNC_POL;
            vs_q   <= ~SYNC_POL;
            vo_q   <= 1'b0;
            tick_q <= 1'b0;
            fs_q   <= 1'b0;
        end else begin
            div_q  <= div_d;
            hc_q   <= hc_d;
            vc_q   <= vc_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            vo_q   <= vo_d;
            tick_q <= tick_d;
            fs_q   <= fs_d;
        end
    end

    assign pix_tick     = tick_q;
    assign horiz_sync   = hs_q;
    assign vert_sync    = vs_q;
    assign video_on     = vo_q;
    assign pixel_column = hc_q;
    assign pixel_row    = vc_q;
    assign frame_start  = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen

module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_d = 1'b0;
    logic rst_1 = 1'b0;
    logic rst_s = 1'b0;

    always #5 clk = ~clk;

    // default instance
    logic       d_tick, d_hs, d_vs, d_vo, d_fs;
    logic [9:0] d_col, d_row;
    // CLK_DIV = 1 instance
    logic       o_tick, o_hs, o_vs, o_vo, o_fs;
    logic [9:0] o_col, o_row;
    // small-geometry instance, active-high syncs
    logic       s_tick, s_hs, s_vs, s_vo, s_fs;
    logic [9:0] s_col, s_row;

    vga_timing_gen u_def (
        .clk(clk), .reset(rst_d), .pix_tick(d_tick), .horiz_sync(d_hs), .vert_sync(d_vs),
        .video_on(d_vo), .pixel_column(d_col), .pixel_row(d_row), .frame_start(d_fs)
    );

    vga_timing_gen #(.CLK_DIV(1)) u_div1 (
        .clk(clk), .reset(rst_1), .pix_tick(o_tick), .horiz_sync(o_hs), .vert_sync(o_vs),
        .video_on(o_vo), .pixel_column(o_col), .pixel_row(o_row), .frame_start(o_fs)
    );

    vga_timing_gen #(
        .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b1)
    ) u_small (
        .clk(clk), .reset(rst_s), .pix_tick(s_tick), .horiz_sync(s_hs), .vert_sync(s_vs),
        .video_on(s_vo), .pixel_column(s_col), .pixel_row(s_row), .frame_start(s_fs)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check_vec(input string name, input logic [24:0] act, input logic [24:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got col=%0d row=%0d vo/hs/vs/tick/fs=%b, expected col=%0d row=%0d vo/hs/vs/tick/fs=%b",
                     name, act[24:15], act[14:5], act[4:0], exp[24:15], exp[14:5], exp[4:0]);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: position derived arithmetically from the number of edges since release.
    function automatic logic [24:0] model(input int n, input int cd, input int ha, input int hf,
                                          input int hsw, input int hb, input int va, input int vf,
                                          input int vsw, input int vb, input logic pol);
        int ht, vt, t, p, hc, vc;
        logic vo, hs, vs, tk, fs;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        if (n == 0) return {10'(ht - 1), 10'(vt - 1), 1'b0, ~pol, ~pol, 1'b0, 1'b0};
        t  = n - 1;
        p  = t / cd;
        hc = p % ht;
        vc = (p / ht) % vt;
        tk = ((t % cd) == 0);
        fs = tk && (hc == 0) && (vc == 0);
        vo = (hc < ha) && (vc < va);
        hs = ((hc >= ha + hf) && (hc < ha + hf + hsw)) ? pol : ~pol;
        vs = ((vc >= va + vf) && (vc < va + vf + vsw)) ? pol : ~pol;
        return {10'(hc), 10'(vc), vo, hs, vs, tk, fs};
    endfunction

    int n_d, n_1, n_s;
    always @(posedge clk or posedge rst_d) if (rst_d) n_d <= 0; else n_d <= n_d + 1;
    always @(posedge clk or posedge rst_1) if (rst_1) n_1 <= 0; else n_1 <= n_1 + 1;
    always @(posedge clk or posedge rst_s) if (rst_s) n_s <= 0; else n_s <= n_s + 1;

    logic checking = 1'b0;
    always @(negedge clk) begin
        if (checking) begin
            check_vec("cont_default", {d_col, d_row, d_vo, d_hs, d_vs, d_tick, d_fs},
                      model(n_d, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
            check_vec("cont_div1", {o_col, o_row, o_vo, o_hs, o_vs, o_tick, o_fs},
                      model(n_1, 1, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
            check_vec("cont_small", {s_col, s_row, s_vo, s_hs, s_vs, s_tick, s_fs},
                      model(n_s, 2, 8, 2, 3, 3, 6, 1, 2, 2, 1'b1));
        end
    end

    typedef struct {
        int         edge_n;
        logic [9:0] col;
        logic [9:0] row;
        logic       vo, hs, vs, tick, fs;
    } vec_t;

    localparam logic [24:0] DEF_RST   = {10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam logic [24:0] SMALL_RST = {10'd15, 10'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[9];
        int starts[$];
        int fs_edges[$];
        int hs_low, vo_high, tick_low, vs_cnt, first_vs, e;
        logic [9:0] pc, pr;

        tbl = '{
            '{1,    10'd0,   10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1},
            '{2,    10'd0,   10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0},
            '{4,    10'd0,   10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0},
            '{5,    10'd1,   10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0},
            '{2561, 10'd640, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0},
            '{2625, 10'd656, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0},
            '{3008, 10'd751, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0},
            '{3009, 10'd752, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0},
            '{3201, 10'd0,   10'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0}
        };

        // Reset with no clock edge yet.
        #1;
        rst_d = 1'b1; rst_1 = 1'b1; rst_s = 1'b1;
        #1;
        check_vec("reset_default", {d_col, d_row, d_vo, d_hs, d_vs, d_tick, d_fs}, DEF_RST);
        check_vec("reset_small", {s_col, s_row, s_vo, s_hs, s_vs, s_tick, s_fs}, SMALL_RST);
        checking = 1'b1;

        // Default instance: table vectors and one-line measurements.
        @(negedge clk); #1 rst_d = 1'b0;
        hs_low = 0; vo_high = 0;
        for (int i = 1; i <= 3300; i++) begin
            @(negedge clk);
            foreach (tbl[k]) begin
                if (tbl[k].edge_n == i)
                    check_vec($sformatf("table_edge_%0d", i),
                              {d_col, d_row, d_vo, d_hs, d_vs, d_tick, d_fs},
                              {tbl[k].col, tbl[k].row, tbl[k].vo, tbl[k].hs, tbl[k].vs, tbl[k].tick, tbl[k].fs});
            end
            if (i <= 3200 && !d_hs) hs_low++;
            if (i <= 3200 && d_vo) vo_high++;
            if (d_col == 10'd0 && d_tick) starts.push_back(i);
        end
        check_int("def_hsync_low_clk", hs_low, 384);
        check_int("def_video_on_clk", vo_high, 2560);
        check_int("def_line_starts", starts.size(), 2);
        if (starts.size() >= 2) check_int("def_line_period", starts[1] - starts[0], 3200);

        // Mid-frame asynchronous reset at column 300.
        e = 3300;
        while (!(d_col == 10'd300 && d_row == 10'd1) && e < 5000) begin
            @(negedge clk);
            e++;
        end
        check_int("def_reach_col300", e, 4401);
        #2 rst_d = 1'b1;
        #1 check_vec("def_async_reset", {d_col, d_row, d_vo, d_hs, d_vs, d_tick, d_fs}, DEF_RST);
        @(negedge clk); #1 rst_d = 1'b0;
        @(negedge clk);
        check_vec("def_restart", {d_col, d_row, d_vo, d_hs, d_vs, d_tick, d_fs},
                  {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1});

        // CLK_DIV = 1 instance.
        @(negedge clk); #1 rst_1 = 1'b0;
        starts.delete();
        hs_low = 0; tick_low = 0;
        for (int i = 1; i <= 1700; i++) begin
            @(negedge clk);
            if (!o_tick) tick_low++;
            if (i <= 800 && !o_hs) hs_low++;
            if (o_col == 10'd0) starts.push_back(i);
        end
        check_int("div1_tick_low", tick_low, 0);
        check_int("div1_hsync_low_clk", hs_low, 96);
        check_int("div1_line_starts", starts.size(), 3);
        if (starts.size() >= 2) check_int("div1_line_period", starts[1] - starts[0], 800);

        // Small instance: two frames.
        @(negedge clk); #1 rst_s = 1'b0;
        vs_cnt = 0; first_vs = -1; pc = 10'd15; pr = 10'd10;
        for (int i = 1; i <= 714; i++) begin
            @(negedge clk);
            if (s_fs) begin
                fs_edges.push_back(i);
                if (i > 1) begin
                    check_int("small_wrap_prev_col", int'(pc), 15);
                    check_int("small_wrap_prev_row", int'(pr), 10);
                    check_int("small_wrap_col", int'(s_col), 0);
                    check_int("small_wrap_row", int'(s_row), 0);
                end
            end
            if (i <= 352 && s_vs) begin
                vs_cnt++;
                if (first_vs < 0) first_vs = i;
            end
            pc = s_col;
            pr = s_row;
        end
        check_int("small_fs_count", fs_edges.size(), 3);
        if (fs_edges.size() >= 3) begin
            check_int("small_frame_period_a", fs_edges[1] - fs_edges[0], 352);
            check_int("small_frame_period_b", fs_edges[2] - fs_edges[1], 352);
        end
        check_int("small_vsync_clk", vs_cnt, 64);
        check_int("small_vsync_first_edge", first_vs, 225);

        // Randomized reset placement on the small instance; the continuous
        // model check covers every cycle around each reset.
        for (int r = 0; r < 20; r++) begin
            repeat ($urandom_range(1, 400)) @(negedge clk);
            #($urandom_range(1, 3)) rst_s = 1'b1;
            #1 check_vec("small_async_reset", {s_col, s_row, s_vo, s_hs, s_vs, s_tick, s_fs}, SMALL_RST);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            @(negedge clk); #1 rst_s = 1'b0;
        end
        repeat (400) @(negedge clk);

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
